// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks a grant until the owner releases it.
// Define RR_LOCK_ARBITER_HOLD_LIMIT_EN to add a hold counter that forces release after HOLD_MAX.
module rr_lock_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = $clog2(N_REQ),
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_pos;
  logic [IDX_W-1:0] w_win;
  logic             w_found;
  logic             w_limit;
  logic             w_release;
  logic             w_load;

  if (N_REQ < 2 || N_REQ > 32 || HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_param_check
    $error("rr_lock_arbiter: parameter out of range");
  end

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_idx = w_idx | IDX_W'(i);
    end
  end

  assign w_next_ptr = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;

  // On release the search starts just past the current owner, in the same cycle.
  assign w_base = (r_state == StLock) ? w_next_ptr : r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = w_base;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end
      w_pos = (int'(w_pos) == N_REQ - 1) ? '0 : w_pos + 1'b1;
    end
  end

  assign w_release = (r_state == StLock) && (rel || w_limit);
  assign w_load    = w_found && ((r_state == StIdle) || w_release);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_gnt   <= N_REQ'(1) << w_win;
            r_state <= StLock;
          end
        end
        StLock: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            if (w_found) begin
              r_gnt <= N_REQ'(1) << w_win;
            end else begin
              r_gnt   <= '0;
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_gnt   <= '0;
        end
      endcase
    end
  end

`ifdef RR_LOCK_ARBITER_HOLD_LIMIT_EN
  logic [15:0] r_cnt;
  logic        r_timeout;

  assign w_limit = (r_state == StLock) && (r_cnt == 16'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_limit && !rel;
      if (w_load || w_release) begin
        r_cnt <= '0;
      end else if (r_state == StLock) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_limit = 1'b0;
  assign timeout = 1'b0;
`endif

  assign gnt     = r_gnt;
  assign gnt_idx = w_idx;
  assign gnt_vld = |r_gnt;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an integer-level behavioural model.
module tb_rr_lock_arbiter;
  localparam int N  = 4;
  localparam int HM = 4;
`ifdef RR_LOCK_ARBITER_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_vld;
  logic         timeout;

  int n_pass  = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  rr_lock_arbiter #(
    .N_REQ   (N),
    .IDX_W   (2),
    .HOLD_MAX(HM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rel    (rel),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: owner index (-1 = none), pointer, edge of last grant load.
  int m_owner, m_ptr, m_edge, m_load;
  bit m_to;

  function automatic int pick(input int base, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_edge  <= 0;
      m_load  <= 0;
      m_to    <= 1'b0;
    end else begin : mdl
      int e, w, base;
      bit lim;
      e = m_edge + 1;
      m_edge <= e;
      m_to   <= 1'b0;
      if (m_owner < 0) begin
        w = pick(m_ptr, req);
        if (w >= 0) begin
          m_owner <= w;
          m_load  <= e;
        end
      end else begin
        lim = HOLD_EN && ((e - m_load) == HM);
        if (rel || lim) begin
          base = (m_owner + 1) % N;
          w    = pick(base, req);
          m_ptr   <= base;
          m_owner <= w;
          m_load  <= e;
          m_to    <= lim && !rel;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      chk("mdl_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("mdl_idx", 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("mdl_vld", 32'(gnt_vld), 32'(m_owner >= 0));
      chk("mdl_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    repeat (2) tick();
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_vld", 32'(gnt_vld), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // First grant latency and back-to-back handover.
    req = 4'b0110;
    tick();
    chk("first_gnt", 32'(gnt), 32'h2);
    chk("first_idx", 32'(gnt_idx), 32'd1);
    rel = 1'b1;
    tick();
    chk("handover_gnt", 32'(gnt), 32'h4);
    chk("handover_idx", 32'(gnt_idx), 32'd2);
    req = '0;
    tick();
    chk("release_idle", 32'(gnt), 32'd0);
    rel = 1'b0;

    // Full rotation with wrap.
    do_reset();
    req = 4'b1111;
    tick();
    chk("rot_0", 32'(gnt), 32'h1);
    rel = 1'b1;
    tick();
    chk("rot_1", 32'(gnt), 32'h2);
    tick();
    chk("rot_2", 32'(gnt), 32'h4);
    tick();
    chk("rot_3", 32'(gnt), 32'h8);
    tick();
    chk("rot_wrap", 32'(gnt), 32'h1);

    // Owner 2 drops its request but keeps the lock until rel.
    req = 4'b0100;
    tick();
    chk("own2_gnt", 32'(gnt), 32'h4);
    rel = 1'b0;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("own2_hold", 32'(gnt), 32'h4);
    end
    rel = 1'b1;
    tick();
    chk("own2_rel_idle", 32'(gnt), 32'd0);
    chk("own2_rel_vld", 32'(gnt_vld), 32'd0);
    rel = 1'b0;

    // Sole requester is re-granted back-to-back.
    do_reset();
    req = 4'b0001;
    tick();
    chk("solo_gnt", 32'(gnt), 32'h1);
    rel = 1'b1;
    tick();
    chk("solo_regrant", 32'(gnt), 32'h1);
    rel = 1'b0;
    tick();
    chk("solo_hold", 32'(gnt), 32'h1);

    // Hold limit.
    do_reset();
    req = 4'b0011;
    tick();
    chk("hold_load", 32'(gnt), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pre_gnt", 32'(gnt), 32'h1);
      chk("hold_pre_to", 32'(timeout), 32'd0);
    end
    tick();
`ifdef RR_LOCK_ARBITER_HOLD_LIMIT_EN
    chk("hold_force_gnt", 32'(gnt), 32'h2);
    chk("hold_force_to", 32'(timeout), 32'd1);
    tick();
    chk("hold_after_gnt", 32'(gnt), 32'h2);
    chk("hold_after_to", 32'(timeout), 32'd0);
`else
    chk("nolimit_gnt", 32'(gnt), 32'h1);
    chk("nolimit_to", 32'(timeout), 32'd0);
    tick();
    chk("nolimit_gnt2", 32'(gnt), 32'h1);
`endif

    // Asynchronous reset mid-lock, between edges.
    req = 4'b1111;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_vld", 32'(gnt_vld), 32'd0);
    chk("async_rst_to", 32'(timeout), 32'd0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      req = N'($urandom);
      rel = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
